// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory load/store controller.
package dmem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_RD   = 2'd1,
    DMC_WR   = 2'd2,
    DMC_RESP = 2'd3
  } dmc_state_e;

  // Width codes with no RV32I meaning for the given direction.
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake plus BRAM port bundle of the data-memory controller.
interface dmem_ctrl_if #(parameter int unsigned ADDR_W = 10);
  import dmem_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [DATA_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                busy;
  logic [ADDR_W-1:0]   mem_r_addr;
  logic                mem_r_enb;
  logic [DATA_W-1:0]   mem_r_dat;
  logic [ADDR_W-1:0]   mem_w_addr;
  logic [DATA_W-1:0]   mem_w_dat;
  logic [MASK_W-1:0]   mem_w_enb;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
    input  mem_r_addr, mem_r_enb, mem_w_addr, mem_w_dat, mem_w_enb
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_r_dat,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
    output mem_r_addr, mem_r_enb, mem_w_addr, mem_w_dat, mem_w_enb
  );

endinterface

// File: rtl/dmem_align.sv
// Lane steering: sub-word load extraction, store lane merge and alignment check.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rword,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word,
  output logic              misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rword[{lane, 3'b000} +: 8];
  assign half_v = rword[{lane[1], 4'b0000} +: 16];

  // funct3[1:0] encodes access size for both loads and stores.
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane;
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   load_data = {{16{half_v[15]}}, half_v};
      F3_LW:   load_data = rword;
      F3_LBU:  load_data = {24'd0, byte_v};
      F3_LHU:  load_data = {16'd0, half_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = rword;
    case (funct3)
      F3_SB:   store_word[{lane, 3'b000} +: 8]    = wdata[7:0];
      F3_SH:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer for a word-only BRAM; sub-word stores become read-modify-write.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);

  dmc_state_e          state;
  logic                lat_we;
  logic [2:0]          lat_f3;
  logic [ADDR_W+1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                idle;
  logic [2:0]          al_f3;
  logic [1:0]          al_lane;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   store_word;
  logic                misalign;
  logic                fault_c;

  assign idle          = (state == DMC_IDLE);
  assign bus.req_ready = idle;

  // In IDLE the aligner screens the incoming request; afterwards it works on the latched one.
  assign al_f3   = idle ? bus.req_funct3    : lat_f3;
  assign al_lane = idle ? bus.req_addr[1:0] : lat_addr[1:0];

  dmem_align u_align (
    .funct3     (al_f3),
    .lane       (al_lane),
    .rword      (bus.mem_r_dat),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misalign   (misalign)
  );

  assign fault_c = misalign
                 | (|bus.req_addr[DATA_W-1:ADDR_W+2])
                 | illegal_f3(bus.req_we, bus.req_funct3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DMC_IDLE;
      lat_we         <= 1'b0;
      lat_f3         <= '0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_r_enb  <= 1'b0;
      bus.mem_r_addr <= '0;
      bus.mem_w_enb  <= '0;
      bus.mem_w_addr <= '0;
      bus.mem_w_dat  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_r_enb  <= 1'b0;
      bus.mem_r_addr <= '0;
      bus.mem_w_enb  <= '0;
      bus.mem_w_addr <= '0;
      bus.mem_w_dat  <= '0;

      case (state)
        DMC_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            lat_addr  <= bus.req_addr[ADDR_W+1:0];
            lat_wdata <= bus.req_wdata;
            bus.busy  <= 1'b1;
            if (fault_c) begin
              state          <= DMC_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_we && (bus.req_funct3 == F3_SW)) begin
              state          <= DMC_WR;
              bus.mem_w_enb  <= {MASK_W{1'b1}};
              bus.mem_w_addr <= bus.req_addr[ADDR_W+1:2];
              bus.mem_w_dat  <= bus.req_wdata;
            end else begin
              state          <= DMC_RD;
              bus.mem_r_enb  <= 1'b1;
              bus.mem_r_addr <= bus.req_addr[ADDR_W+1:2];
            end
          end
        end

        // Read data is consumed at this edge, either as a load result or as the merge base.
        DMC_RD: begin
          if (lat_we) begin
            state          <= DMC_WR;
            bus.mem_w_enb  <= {MASK_W{1'b1}};
            bus.mem_w_addr <= lat_addr[ADDR_W+1:2];
            bus.mem_w_dat  <= store_word;
          end else begin
            state          <= DMC_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_data;
          end
        end

        DMC_WR: begin
          state          <= DMC_RESP;
          bus.resp_valid <= 1'b1;
        end

        DMC_RESP: begin
          state    <= DMC_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= DMC_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
